// File: rtl/bp_be_instr_encoder.sv
// Encodes abstract BE commands (GPR access, load/store, fence.i) into short
// RV64 instruction sequences issued over a valid/ready injection port.
module bp_be_instr_encoder #(
    parameter logic [11:0] csr_data_addr_p = 12'h7B2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_v_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [4:0]  cmd_rd_i,
    input  logic [4:0]  cmd_rs1_i,
    input  logic [4:0]  cmd_rs2_i,
    input  logic [1:0]  cmd_size_i,
    input  logic        cmd_unsigned_i,
    input  logic [11:0] cmd_imm_i,
    input  logic        cmd_postexec_i,
    output logic        instr_v_o,
    output logic [31:0] instr_o,
    input  logic        instr_ready_i,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned SEQ_MAX = 3;

    localparam logic [2:0] OP_RD_GPR  = 3'd0;
    localparam logic [2:0] OP_WR_GPR  = 3'd1;
    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_STORE   = 3'd3;
    localparam logic [2:0] OP_FENCE_I = 3'd4;

    localparam logic [31:0] FENCE_WORD   = 32'h0FF0000F;
    localparam logic [31:0] FENCE_I_WORD = 32'h0000100F;
    localparam logic [31:0] EBREAK_WORD  = 32'h00100073;

    typedef enum logic {S_IDLE, S_EMIT} state_e;

    state_e      state;
    logic [31:0] seq_q [SEQ_MAX];
    logic [1:0]  len_q;
    logic [1:0]  idx_q;

    logic [31:0] seq_c [SEQ_MAX];
    logic [1:0]  len_c;
    logic        legal_c;
    logic [1:0]  idx_next_c;

    // Build the full sequence for the command currently presented.
    always_comb begin
        for (int i = 0; i < SEQ_MAX; i++) seq_c[i] = 32'h0;
        len_c   = 2'd1;
        legal_c = 1'b1;
        unique case (cmd_op_i)
            OP_RD_GPR:  seq_c[0] = {csr_data_addr_p, cmd_rs1_i, 3'b001, 5'd0, 7'h73};
            OP_WR_GPR:  seq_c[0] = {csr_data_addr_p, 5'd0, 3'b010, cmd_rd_i, 7'h73};
            OP_LOAD: begin
                seq_c[0] = {cmd_imm_i, cmd_rs1_i, cmd_unsigned_i, cmd_size_i, cmd_rd_i, 7'h03};
                legal_c  = !(cmd_unsigned_i && (cmd_size_i == 2'd3));
            end
            OP_STORE: begin
                seq_c[0] = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 1'b0, cmd_size_i,
                            cmd_imm_i[4:0], 7'h23};
                legal_c  = !cmd_unsigned_i;
            end
            OP_FENCE_I: begin
                seq_c[0] = FENCE_WORD;
                seq_c[1] = FENCE_I_WORD;
                len_c    = 2'd2;
            end
            default:    legal_c = 1'b0;
        endcase
        if (cmd_postexec_i) begin
            if (len_c == 2'd2) seq_c[2] = EBREAK_WORD;
            else               seq_c[1] = EBREAK_WORD;
            len_c = len_c + 2'd1;
        end
    end

    assign idx_next_c = idx_q + 2'd1;

    // Command acceptance and word-by-word issue; all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            cmd_ready_o <= 1'b1;
            instr_v_o   <= 1'b0;
            instr_o     <= 32'h0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            len_q       <= 2'd0;
            idx_q       <= 2'd0;
            for (int i = 0; i < SEQ_MAX; i++) seq_q[i] <= 32'h0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd_v_i) begin
                        if (legal_c) begin
                            for (int i = 0; i < SEQ_MAX; i++) seq_q[i] <= seq_c[i];
                            len_q       <= len_c;
                            idx_q       <= 2'd0;
                            instr_o     <= seq_c[0];
                            instr_v_o   <= 1'b1;
                            cmd_ready_o <= 1'b0;
                            state       <= S_EMIT;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (instr_ready_i) begin
                        if (idx_q == len_q - 2'd1) begin
                            instr_v_o   <= 1'b0;
                            cmd_ready_o <= 1'b1;
                            done_o      <= 1'b1;
                            idx_q       <= 2'd0;
                            state       <= S_IDLE;
                        end else begin
                            idx_q   <= idx_next_c;
                            instr_o <= seq_q[idx_next_c];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_instr_encoder.sv
// Table-driven bench for bp_be_instr_encoder with a word scoreboard.
module tb_bp_be_instr_encoder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_v_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [4:0]  cmd_rd_i;
    logic [4:0]  cmd_rs1_i;
    logic [4:0]  cmd_rs2_i;
    logic [1:0]  cmd_size_i;
    logic        cmd_unsigned_i;
    logic [11:0] cmd_imm_i;
    logic        cmd_postexec_i;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic        instr_ready_i;
    logic        done_o;
    logic        err_o;

    bp_be_instr_encoder dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .cmd_v_i        (cmd_v_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_rd_i       (cmd_rd_i),
        .cmd_rs1_i      (cmd_rs1_i),
        .cmd_rs2_i      (cmd_rs2_i),
        .cmd_size_i     (cmd_size_i),
        .cmd_unsigned_i (cmd_unsigned_i),
        .cmd_imm_i      (cmd_imm_i),
        .cmd_postexec_i (cmd_postexec_i),
        .instr_v_o      (instr_v_o),
        .instr_o        (instr_o),
        .instr_ready_i  (instr_ready_i),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] imm;
        logic        post;
        logic        is_err;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          stall;
        logic        rnd;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          stall_left = 0;
    logic        rnd_ready = 1'b0;
    logic [31:0] exp_q [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = 32'h0;
    logic        prev_done  = 1'b0;
    logic        last_emptied = 1'b0;

    function automatic void chk(input bit ok, input string name,
                                input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Consumer ready: forced-low stall window, then random or always-ready.
    always @(posedge clk_i) begin
        #1;
        if (stall_left > 0) begin
            instr_ready_i = 1'b0;
            stall_left--;
        end else begin
            instr_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop, hold-under-backpressure, pulse checks.
    always @(negedge clk_i) begin
        logic [31:0] exp_w;
        if (prev_stall)
            chk(instr_v_o && (instr_o == prev_word), "hold_stable", instr_o, prev_word);
        if (instr_v_o)
            chk(!cmd_ready_o, "cmd_ready_low_in_emit", 32'(cmd_ready_o), 32'd0);
        if (done_o) begin
            done_cnt++;
            chk(last_emptied, "done_after_last_word", 32'(last_emptied), 32'd1);
            chk(!prev_done, "done_one_cycle", 32'(prev_done), 32'd0);
        end
        if (err_o) err_cnt++;
        last_emptied = 1'b0;
        if (instr_v_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_word", instr_o, 32'h0);
            end else begin
                exp_w = exp_q.pop_front();
                chk(instr_o == exp_w, "word", instr_o, exp_w);
                last_emptied = (exp_q.size() == 0);
            end
        end
        prev_stall = instr_v_o && !instr_ready_i && !reset_i;
        prev_word  = instr_o;
        prev_done  = done_o;
    end

    task automatic drive_cmd(input vec_t e);
        cmd_op_i       = e.op;
        cmd_rd_i       = e.rd;
        cmd_rs1_i      = e.rs1;
        cmd_rs2_i      = e.rs2;
        cmd_size_i     = e.size;
        cmd_unsigned_i = e.uns;
        cmd_imm_i      = e.imm;
        cmd_postexec_i = e.post;
        cmd_v_i        = 1'b1;
    endtask

    task automatic run_cmd(input vec_t e);
        int d0, e0, guard;
        drive_cmd(e);
        rnd_ready = e.rnd;
        guard = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (!cmd_ready_o) begin
            chk(1'b0, "cmd_accept_timeout", 32'(cmd_ready_o), 32'd1);
            cmd_v_i = 1'b0;
            return;
        end
        d0 = done_cnt;
        e0 = err_cnt;
        if (!e.is_err) begin
            if (e.n > 0) exp_q.push_back(e.w0);
            if (e.n > 1) exp_q.push_back(e.w1);
            if (e.n > 2) exp_q.push_back(e.w2);
        end
        stall_left = e.stall;
        @(posedge clk_i); #1;
        cmd_v_i = 1'b0;
        @(negedge clk_i);
        chk(instr_v_o == !e.is_err, "first_valid_latency", 32'(instr_v_o), 32'(!e.is_err));
        chk(err_o == e.is_err, "err_pulse", 32'(err_o), 32'(e.is_err));
        guard = 0;
        while (done_cnt == d0 && err_cnt == e0 && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        chk(guard < 200, "completion_timeout", 32'(guard), 32'd200);
        @(posedge clk_i); #1;
        chk(done_cnt - d0 == (e.is_err ? 0 : 1), "done_count", 32'(done_cnt - d0), 32'(!e.is_err));
        chk(err_cnt - e0 == (e.is_err ? 1 : 0), "err_count", 32'(err_cnt - e0), 32'(e.is_err));
        chk(exp_q.size() == 0, "words_left", 32'(exp_q.size()), 32'd0);
        rnd_ready = 1'b0;
    endtask

    initial begin
        int d0;
        //          op    rd     rs1    rs2    sz    u     imm      post  err  n  w0            w1            w2            stall rnd
        tbl[0]  = '{3'd0, 5'd0,  5'd5,  5'd0,  2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 1, 32'h7B229073, 32'h0,        32'h0,        0, 1'b0};
        tbl[1]  = '{3'd1, 5'd10, 5'd0,  5'd0,  2'd0, 1'b0, 12'h000, 1'b1, 1'b0, 2, 32'h7B202573, 32'h00100073, 32'h0,        0, 1'b0};
        tbl[2]  = '{3'd2, 5'd6,  5'd2,  5'd0,  2'd3, 1'b0, 12'h008, 1'b0, 1'b0, 1, 32'h00813303, 32'h0,        32'h0,        0, 1'b0};
        tbl[3]  = '{3'd2, 5'd6,  5'd2,  5'd0,  2'd3, 1'b1, 12'h008, 1'b0, 1'b1, 0, 32'h0,        32'h0,        32'h0,        0, 1'b0};
        tbl[4]  = '{3'd3, 5'd0,  5'd1,  5'd7,  2'd2, 1'b0, 12'hFFC, 1'b0, 1'b0, 1, 32'hFE70AE23, 32'h0,        32'h0,        3, 1'b0};
        tbl[5]  = '{3'd4, 5'd0,  5'd0,  5'd0,  2'd0, 1'b0, 12'h000, 1'b1, 1'b0, 3, 32'h0FF0000F, 32'h0000100F, 32'h00100073, 0, 1'b1};
        tbl[6]  = '{3'd5, 5'd1,  5'd2,  5'd3,  2'd0, 1'b0, 12'h000, 1'b0, 1'b1, 0, 32'h0,        32'h0,        32'h0,        0, 1'b0};
        tbl[7]  = '{3'd3, 5'd0,  5'd1,  5'd7,  2'd2, 1'b1, 12'h004, 1'b0, 1'b1, 0, 32'h0,        32'h0,        32'h0,        0, 1'b0};
        tbl[8]  = '{3'd2, 5'd31, 5'd31, 5'd0,  2'd1, 1'b1, 12'hFFF, 1'b1, 1'b0, 2, 32'hFFFFDF83, 32'h00100073, 32'h0,        0, 1'b1};
        tbl[9]  = '{3'd7, 5'd0,  5'd0,  5'd0,  2'd0, 1'b0, 12'h000, 1'b1, 1'b1, 0, 32'h0,        32'h0,        32'h0,        0, 1'b0};
        tbl[10] = '{3'd4, 5'd9,  5'd9,  5'd9,  2'd3, 1'b1, 12'h123, 1'b0, 1'b0, 2, 32'h0FF0000F, 32'h0000100F, 32'h0,        2, 1'b0};
        tbl[11] = '{3'd0, 5'd17, 5'd0,  5'd22, 2'd3, 1'b1, 12'hABC, 1'b1, 1'b0, 2, 32'h7B201073, 32'h00100073, 32'h0,        0, 1'b1};
        tbl[12] = '{3'd3, 5'd0,  5'd0,  5'd31, 2'd3, 1'b0, 12'h020, 1'b0, 1'b0, 1, 32'h03F03023, 32'h0,        32'h0,        0, 1'b0};

        reset_i = 1'b1;
        cmd_v_i = 1'b0;
        instr_ready_i = 1'b1;
        drive_cmd(tbl[0]);
        cmd_v_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk(instr_v_o == 1'b0, "reset_instr_v", 32'(instr_v_o), 32'd0);
        chk(instr_o == 32'h0, "reset_instr", instr_o, 32'h0);
        chk(done_o == 1'b0, "reset_done", 32'(done_o), 32'd0);
        chk(err_o == 1'b0, "reset_err", 32'(err_o), 32'd0);
        chk(cmd_ready_o == 1'b1, "reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        for (int i = 0; i < NV; i++) run_cmd(tbl[i]);

        // Reset while the second fence word is on the port abandons the sequence.
        drive_cmd(tbl[10]);
        @(negedge clk_i);
        chk(cmd_ready_o == 1'b1, "rst_seq_accept", 32'(cmd_ready_o), 32'd1);
        exp_q.push_back(32'h0FF0000F);
        exp_q.push_back(32'h0000100F);
        d0 = done_cnt;
        @(posedge clk_i); #1;
        cmd_v_i = 1'b0;
        @(negedge clk_i);
        chk(instr_v_o && instr_o == 32'h0FF0000F, "rst_seq_first_word", instr_o, 32'h0FF0000F);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk(instr_v_o == 1'b0, "rst_seq_valid_drop", 32'(instr_v_o), 32'd0);
        chk(cmd_ready_o == 1'b1, "rst_seq_cmd_ready", 32'(cmd_ready_o), 32'd1);
        exp_q.delete();
        repeat (4) @(posedge clk_i);
        #1;
        chk(done_cnt == d0, "rst_seq_no_done", 32'(done_cnt - d0), 32'd0);

        run_cmd(tbl[2]);
        run_cmd(tbl[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
